// File: rtl/freq_sweep_sequencer.sv
// freq_sweep_sequencer: steps the generator's 3-bit freq_select through a
// programmed sweep (hold, up, down, ping-pong). Each level is held for a
// programmable dwell. The sweep runs for a programmable number of passes,
// and the generator is held in reset whenever no sweep is running.
//
// Optional build macro: SWEEP_STATUS_EN exports the completed-pass counter
// as the pass_cnt output.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin a sweep (accepted only in IDLE, and only with abort low)
//   abort        stop the sweep on the next edge, with no done pulse
//   mode         00 hold, 01 up, 10 down, 11 ping-pong (latched at start)
//   sel_lo       lower level bound (latched at start)
//   sel_hi       upper level bound (latched at start)
//   dwell        cycles per level, 0 behaves as 1 (latched at start)
//   loops        number of passes, 0 = run until abort (latched at start)
//   freq_select  level driven to the generator
//   gen_reset    active-high generator reset, high whenever not in RUN
//   busy         high while in RUN
//   done         one-cycle pulse after the final pass
//   step_strobe  one-cycle pulse on every cycle a new level is applied
//   pass_cnt     completed passes, saturating (SWEEP_STATUS_EN only)
module freq_sweep_sequencer #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [2:0]         sel_lo,
  input  logic [2:0]         sel_hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
  output logic [2:0]         freq_select,
  output logic               gen_reset,
  output logic               busy,
  output logic               done,
  output logic               step_strobe
`ifdef SWEEP_STATUS_EN
  ,
  output logic [LOOP_W-1:0]  pass_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;

  state_t             state;
  logic [1:0]         mode_q;
  logic [2:0]         lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_m1_q, dwell_cnt;
  logic [LOOP_W-1:0]  loops_q, pass_q;
  logic               dir_up;

  logic [2:0]         cfg_lo, cfg_hi, cfg_first, pass_first, step_level;
  logic [DWELL_W-1:0] cfg_dwell_m1;
  logic [LOOP_W-1:0]  pass_inc;
  logic               pass_end, next_dir, last_pass;

  // Normalise the configuration presented at start.
  always_comb begin
    cfg_lo       = (sel_lo > sel_hi) ? sel_hi : sel_lo;
    cfg_hi       = (sel_lo > sel_hi) ? sel_lo : sel_hi;
    cfg_first    = (mode == M_DOWN) ? cfg_hi : cfg_lo;
    cfg_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  end

  // Next level within the pass, and whether the current level ends the pass.
  always_comb begin
    step_level = freq_select;
    next_dir   = dir_up;
    pass_end   = 1'b1;
    pass_first = (mode_q == M_DOWN) ? hi_q : lo_q;
    case (mode_q)
      M_HOLD: pass_end = 1'b1;
      M_UP: begin
        step_level = freq_select + 3'd1;
        pass_end   = (freq_select == hi_q);
      end
      M_DOWN: begin
        step_level = freq_select - 3'd1;
        pass_end   = (freq_select == lo_q);
      end
      default: begin
        // Ping-pong: climb to hi, then descend; the pass ends just before
        // the descent would revisit lo.
        if (dir_up && (freq_select != hi_q)) begin
          step_level = freq_select + 3'd1;
        end else begin
          step_level = freq_select - 3'd1;
          next_dir   = 1'b0;
        end
        pass_end = (hi_q == lo_q) || (step_level == lo_q);
      end
    endcase
    pass_inc  = (&pass_q) ? pass_q : pass_q + LOOP_W'(1);
    last_pass = (loops_q != '0) && (pass_inc == loops_q);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_m1_q  <= '0;
      dwell_cnt   <= '0;
      loops_q     <= '0;
      pass_q      <= '0;
      dir_up      <= 1'b1;
      freq_select <= '0;
      gen_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done        <= 1'b0;
          step_strobe <= 1'b0;
          if (start && !abort) begin
            state       <= S_RUN;
            mode_q      <= mode;
            lo_q        <= cfg_lo;
            hi_q        <= cfg_hi;
            dwell_m1_q  <= cfg_dwell_m1;
            loops_q     <= loops;
            pass_q      <= '0;
            dwell_cnt   <= '0;
            dir_up      <= 1'b1;
            freq_select <= cfg_first;
            step_strobe <= 1'b1;
            busy        <= 1'b1;
            gen_reset   <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            gen_reset   <= 1'b1;
            step_strobe <= 1'b0;
          end else if (dwell_cnt == dwell_m1_q) begin
            dwell_cnt <= '0;
            if (pass_end) begin
              pass_q <= pass_inc;
              if (last_pass) begin
                state       <= S_DONE;
                done        <= 1'b1;
                busy        <= 1'b0;
                gen_reset   <= 1'b1;
                step_strobe <= 1'b0;
              end else begin
                freq_select <= pass_first;
                dir_up      <= 1'b1;
                step_strobe <= 1'b1;
              end
            end else begin
              freq_select <= step_level;
              dir_up      <= next_dir;
              step_strobe <= 1'b1;
            end
          end else begin
            dwell_cnt   <= dwell_cnt + DWELL_W'(1);
            step_strobe <= 1'b0;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SWEEP_STATUS_EN
  assign pass_cnt = pass_q;
`endif

endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// Scoreboard bench for freq_sweep_sequencer: expected per-cycle output words
// {done, busy, gen_reset, step_strobe, freq_select} are queued when a sweep is
// launched and popped/compared one per clock after each rising edge.
module tb_freq_sweep_sequencer;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned LOOP_W  = 8;

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [1:0]         mode;
  logic [2:0]         sel_lo, sel_hi;
  logic [DWELL_W-1:0] dwell;
  logic [LOOP_W-1:0]  loops;
  logic [2:0]         freq_select;
  logic               gen_reset, busy, done, step_strobe;
`ifdef SWEEP_STATUS_EN
  logic [LOOP_W-1:0]  pass_cnt;
`endif

  always #5 clk = ~clk;

  freq_sweep_sequencer #(.DWELL_W(DWELL_W), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .sel_lo(sel_lo), .sel_hi(sel_hi), .dwell(dwell), .loops(loops),
    .freq_select(freq_select), .gen_reset(gen_reset), .busy(busy),
    .done(done), .step_strobe(step_strobe)
`ifdef SWEEP_STATUS_EN
    , .pass_cnt(pass_cnt)
`endif
  );

  logic [6:0] obs;
  assign obs = {done, busy, gen_reset, step_strobe, freq_select};

  logic [6:0] exp_q[$];
  int         lvls[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Queue one RUN word per cycle for every level in lvls.
  task automatic push_run(input int dw);
    int d;
    d = (dw == 0) ? 1 : dw;
    foreach (lvls[i])
      for (int k = 0; k < d; k++)
        exp_q.push_back({1'b0, 1'b1, 1'b0, (k == 0), 3'(lvls[i])});
  endtask

  task automatic push_done(input int lv);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 3'(lv)});
  endtask

  task automatic push_idle(input int lv, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 3'(lv)});
  endtask

  task automatic drain(input string tag);
    int c;
    logic [6:0] e;
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val($sformatf("%s[%0d]", tag, c), 32'(obs), 32'(e));
      c++;
      @(posedge clk); #1;
    end
  endtask

  // Launch a sweep, then scramble the config inputs to show they were latched.
  task automatic go(input int m, input int lo, input int hi, input int dw, input int lp);
    mode = 2'(m); sel_lo = 3'(lo); sel_hi = 3'(hi);
    dwell = DWELL_W'(dw); loops = LOOP_W'(lp);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mode   = 2'($urandom);
    sel_lo = 3'($urandom);
    sel_hi = 3'($urandom);
    dwell  = DWELL_W'($urandom_range(0, 9));
    loops  = LOOP_W'($urandom_range(0, 9));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] e;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = '0;
    sel_lo = '0; sel_hi = '0; dwell = '0; loops = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset", 32'(obs), 32'(7'b0010000));
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("idle_after_reset", 32'(obs), 32'(7'b0010000));

    // Up sweep 2..5, dwell 3, one pass.
    lvls = {2, 3, 4, 5};
    push_run(3); push_done(5); push_idle(5, 2);
    go(1, 2, 5, 3, 1);
    drain("up");

    // Ping-pong 1..3, dwell 1, two passes.
    lvls = {};
    for (int p = 0; p < 2; p++) begin
      for (int l = 1; l <= 3; l++) lvls.push_back(l);
      for (int l = 2; l >= 2; l--) lvls.push_back(l);
    end
    push_run(1); push_done(2); push_idle(2, 2);
    go(3, 1, 3, 1, 2);
    drain("pingpong");

    // Down with swapped bounds and zero dwell.
    lvls = {6, 5, 4, 3, 2};
    push_run(0); push_done(2); push_idle(2, 1);
    go(2, 6, 2, 0, 1);
    drain("down_swap");

    // Abort in RUN cycle 10 of an endless up sweep; start while busy ignored.
    lvls = {0, 1};
    push_run(4);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 3'd2});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 3'd2});
    go(1, 0, 7, 4, 0);
    for (int c = 1; c <= 10; c++) begin
      e = exp_q.pop_front();
      check_val($sformatf("abort_run[%0d]", c), 32'(obs), 32'(e));
      if (c == 3) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (c == 10) abort = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    push_idle(2, 3);
    drain("abort_idle");

    // start together with abort in IDLE is refused.
    mode = 2'd1; sel_lo = 3'd5; sel_hi = 3'd6; dwell = DWELL_W'(1); loops = LOOP_W'(1);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    push_idle(2, 3);
    drain("start_abort_idle");

    // Reset mid-sweep, then a hold sweep runs normally.
    lvls = {0, 1, 2};
    push_run(2);
    go(1, 0, 7, 2, 0);
    drain("pre_reset");
    reset = 1'b0;
    #1;
    check_val("reset_mid", 32'(obs), 32'(7'b0010000));
    @(posedge clk); #1;
    check_val("reset_hold", 32'(obs), 32'(7'b0010000));
    reset = 1'b1;
    @(posedge clk); #1;
    lvls = {4, 4, 4};
    push_run(2); push_done(4); push_idle(4, 1);
    go(0, 4, 4, 2, 3);
    drain("hold3");

`ifdef SWEEP_STATUS_EN
    check_val("pass_cnt_after_done", 32'(pass_cnt), 32'd3);
    lvls = {};
    for (int i = 0; i < 300; i++) lvls.push_back(4);
    push_run(2);
    go(0, 4, 4, 2, 0);
    check_val("pass_cnt_cleared", 32'(pass_cnt), 32'd0);
    drain("hold_sat");
    check_val("pass_cnt_sat", 32'(pass_cnt), 32'd255);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    push_idle(4, 2);
    drain("sat_abort");
    check_val("pass_cnt_held", 32'(pass_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_sweep_sequencer.md
Name: freq_sweep_sequencer

Overview:
Sequencer that drives the 3-bit freq_select input of the sine wave generator through a programmed frequency sweep. It supports hold, up, down and ping-pong modes, with a programmable dwell time per level and a programmable pass count. It also controls the generator's reset. It sits between the control/register front end and the generator and uses the same clock.

Parameters:
DWELL_W, 16, width of dwell counter and dwell input
LOOP_W, 8, width of loops input and pass counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request to begin a sweep; sampled only in IDLE
abort  in  1  terminate the sweep; takes effect next cycle
mode  in  2  00 hold, 01 up, 10 down, 11 ping-pong; latched at start
sel_lo  in  3  lower level bound; latched at start
sel_hi  in  3  upper level bound; latched at start
dwell  in  DWELL_W  clock cycles per level; latched at start
loops  in  LOOP_W  passes to run; 0 = run until abort; latched at start
freq_select  out  3  level driven to generator
gen_reset  out  1  active-high reset to generator; high whenever not in RUN
busy  out  1  high in RUN
done  out  1  one-cycle pulse when the final pass completes
step_strobe  out  1  one-cycle pulse on every cycle a new level is applied, including the first

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=0, asynchronous): state IDLE; freq_select=0, gen_reset=1, busy=0, done=0, step_strobe=0; all internal counters cleared.
- Start handling:
  - IDLE and start=1 and abort=0: latch the configuration and go to RUN.
  - In the first RUN cycle: freq_select = first level, step_strobe=1, busy=1, gen_reset=0.
  - start while busy is ignored.
  - start and abort together in IDLE: stay in IDLE.
- Bounds: if sel_lo > sel_hi, the latched bounds are swapped, so lo=min and hi=max.
- Dwell: dwell=0 is treated as 1. Each level is held exactly max(dwell,1) clock cycles.
- Pass sequences:
  - hold: lo (1 level).
  - up: lo..hi.
  - down: hi..lo.
  - ping-pong: lo..hi, then hi-1..lo+1. Pass length is 2*(hi-lo) levels, or 1 level if hi==lo.
- Level transitions: the next level is applied on the cycle after the dwell counter reaches max(dwell,1)-1. The next pass starts on the cycle after the current pass ends; there are no idle gaps.
- Pass counting: the internal pass counter increments at the end of each pass.
  - loops!=0: after the last level of pass number loops, go to DONE.
  - loops=0: passes repeat indefinitely.
- DONE lasts one cycle: done=1, busy=0, gen_reset=1. Then IDLE.
- freq_select keeps its last value in IDLE and DONE.
- Abort in RUN: the next state is IDLE, busy=0, gen_reset=1, and no done pulse is produced. Abort has priority over a level step or pass end in the same cycle.
- Config input changes during RUN have no effect.
- Reset asserted mid-sweep: outputs return to their reset values immediately.

Optional Feature:
SWEEP_STATUS_EN
- Defined: adds output pass_cnt [LOOP_W-1:0] giving the number of completed passes.
  - Reset value 0; cleared when a start is accepted.
  - Saturates at all-ones.
  - Holds its value after DONE or abort.
- Undefined: the port does not exist. The internal pass counter is still present (it is needed for loop termination) but is not exported.

Test Plan:
- Up sweep, mode=01, lo=2, hi=5, dwell=3, loops=1 -> freq_select 2,3,4,5 for 3 cycles each; busy high 12 cycles; 4 step_strobe pulses; done pulse on cycle 13; freq_select stays 5.
- Ping-pong, mode=11, lo=1, hi=3, dwell=1, loops=2 -> freq_select 1,2,3,2,1,2,3,2 on consecutive cycles, then done; step_strobe high all 8 cycles.
- Swapped bounds and zero dwell, mode=10, sel_lo=6, sel_hi=2, dwell=0, loops=1 -> freq_select 6,5,4,3,2, one cycle each, then done.
- Abort, mode=01, lo=0, hi=7, dwell=4, loops=0, abort asserted on cycle 10 -> IDLE next cycle; no done pulse; gen_reset=1; freq_select=2 held; start asserted while busy has no effect.
- Reset mid-sweep, reset=0 during RUN -> freq_select=0, gen_reset=1, busy=0 immediately; after release, a new start runs normally.
- With SWEEP_STATUS_EN, mode=00, lo=hi=4, dwell=2, loops=0, run 600 cycles -> pass_cnt saturates at 255; freq_select constant 4; step_strobe pulses every 2 cycles.
